// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative radix-2 shift-add multiplier with signed/unsigned
// modes, full 2*WIDTH product, truncated WIDTH-bit result and status flags.
//
// state | meaning
// IDLE  | waiting for an operation, inReady high
// CALC  | one shift-add iteration per cycle, WIDTH iterations then one exit cycle
// FIX   | apply sign to magnitude product, compute flags, register outputs
// DONE  | outValid high, outputs held until outReady
module seq_multiplier #(
   parameter int WIDTH = 16,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inValid,
   output logic                 inReady,
   input  logic                 signedMode,
   input  logic [WIDTH-1:0]     operand1,
   input  logic [WIDTH-1:0]     operand2,
   output logic                 outValid,
   input  logic                 outReady,
   output logic [WIDTH-1:0]     result,
   output logic [2*WIDTH-1:0]   product,
   output logic [3:0]           statusOut
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               mode_q, mode_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic [3:0]         status_q, status_d;

   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH:0]     prod_top;

   assign inReady   = (state_q == S_IDLE);
   assign outValid  = (state_q == S_DONE);
   assign product   = product_q;
   assign result    = product_q[WIDTH-1:0];
   assign statusOut = status_q;

   // Next-state, datapath and output-register computation
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      neg_d     = neg_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      status_d  = status_q;

      // Low half of acc holds the remaining multiplier bits; carry out of the
      // high-half add is kept in sum[WIDTH] and shifted back in.
      sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      prod_fix = neg_q ? -acc_q : acc_q;
      prod_top = prod_fix[2*WIDTH-1:WIDTH-1];

      case (state_q)
         S_IDLE: begin
            if (inValid) begin
               mode_d = signedMode;
               cnt_d  = '0;
               if (signedMode) begin
                  // -2^(WIDTH-1) negates to itself, which is the correct
                  // unsigned magnitude
                  mcand_d = operand1[WIDTH-1] ? -operand1 : operand1;
                  acc_d   = {{WIDTH{1'b0}}, (operand2[WIDTH-1] ? -operand2 : operand2)};
                  neg_d   = operand1[WIDTH-1] ^ operand2[WIDTH-1];
               end else begin
                  mcand_d = operand1;
                  acc_d   = {{WIDTH{1'b0}}, operand2};
                  neg_d   = 1'b0;
               end
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (cnt_q == CNT_W'(WIDTH)) begin
               state_d = S_FIX;
            end else begin
               acc_d = {sum, acc_q[WIDTH-1:1]};
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FIX: begin
            product_d   = prod_fix;
            status_d[3] = mode_q && (|prod_top) && !(&prod_top);
            status_d[2] = mode_q && prod_fix[2*WIDTH-1];
            status_d[1] = (prod_fix == '0);
            status_d[0] = !mode_q && (prod_fix[2*WIDTH-1:WIDTH] != '0);
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (outReady) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         mode_q    <= 1'b0;
         neg_q     <= 1'b0;
         mcand_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         status_q  <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         neg_q     <= neg_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         status_q  <= status_d;
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random bench for seq_multiplier at WIDTH=8 with a result scoreboard.
module tb_seq_multiplier;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           inValid = 1'b0;
   logic           inReady;
   logic           signedMode = 1'b0;
   logic [W-1:0]   operand1 = '0;
   logic [W-1:0]   operand2 = '0;
   logic           outValid;
   logic           outReady = 1'b0;
   logic [W-1:0]   result;
   logic [2*W-1:0] product;
   logic [3:0]     statusOut;

   typedef struct {
      logic [2*W-1:0] prod;
      logic [3:0]     st;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   seq_multiplier #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
      .signedMode(signedMode), .operand1(operand1), .operand2(operand2),
      .outValid(outValid), .outReady(outReady), .result(result),
      .product(product), .statusOut(statusOut)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [2*W-1:0] p, input logic [3:0] st);
      exp_t e;
      e.prod = p;
      e.st   = st;
      sb.push_back(e);
   endtask

   // Reference via native multiplication, flags straight from their definitions
   task automatic push_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      logic signed [2*W-1:0] sp;
      logic [2*W-1:0]        p;
      logic [3:0]            st;
      if (s) begin
         sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
         p  = sp;
      end else begin
         p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      end
      st[1] = (p == 0);
      st[2] = s && p[2*W-1];
      st[0] = !s && (p[2*W-1:W] != 0);
      st[3] = s && (sp < -(2 ** (W - 1)) || sp > (2 ** (W - 1)) - 1);
      push_exp(p, st);
   endtask

   // Present an operation and hold it until accepted; operands are scrambled afterwards
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      bit done = 0;
      operand1   = a;
      operand2   = b;
      signedMode = s;
      inValid    = 1'b1;
      for (int n = 0; n < 40 && !done; n++) begin
         if (inReady) done = 1;
         @(posedge clk);
         #1;
      end
      acc_cyc    = cyc;
      inValid    = 1'b0;
      operand1   = W'($urandom);
      operand2   = W'($urandom);
      signedMode = ~s;
      if (!done) chk("accept_timeout", 0, 1);
   endtask

   // Wait for outValid, compare against the scoreboard head, then hand the result off
   task automatic wait_out(input string tag, input bit chk_lat, input bit release_it);
      bit   seen = 0;
      exp_t e;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(posedge clk);
         #1;
         if (outValid) seen = 1;
      end
      if (!seen) begin
         chk({tag, "_out_timeout"}, 0, 1);
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      if (chk_lat) chk({tag, "_latency"}, cyc - acc_cyc, W + 2);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 0, 1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_product"}, product, e.prod);
      chk({tag, "_result"}, result, e.prod[W-1:0]);
      chk({tag, "_status"}, statusOut, e.st);
      if (release_it) begin
         outReady = 1'b1;
         @(posedge clk);
         #1;
         outReady = 1'b0;
         chk({tag, "_inready_after"}, inReady, 1);
         chk({tag, "_outvalid_after"}, outValid, 0);
      end
   endtask

   initial begin
      #2;
      chk("rst_inready", inReady, 1);
      chk("rst_outvalid", outValid, 0);
      chk("rst_product", product, 0);
      chk("rst_status", statusOut, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: unsigned 7*6
      push_exp(16'h002A, 4'b0000);
      start_op(8'd7, 8'd6, 1'b0);
      wait_out("u7x6", 1, 1);

      // 2: signed -3*5
      push_exp(16'hFFF1, 4'b0100);
      start_op(8'hFD, 8'd5, 1'b1);
      wait_out("s_m3x5", 1, 1);

      // 3: 200*200 unsigned then signed
      push_exp(16'h9C40, 4'b0001);
      start_op(8'd200, 8'd200, 1'b0);
      wait_out("u200x200", 1, 1);
      push_exp(16'h0C40, 4'b1000);
      start_op(8'd200, 8'd200, 1'b1);
      wait_out("s_m56x_m56", 1, 1);

      // 4: most negative squared, then zero operands in both modes
      push_exp(16'h4000, 4'b1000);
      start_op(8'h80, 8'h80, 1'b1);
      wait_out("s80x80", 1, 1);
      push_exp(16'h0000, 4'b0010);
      start_op(8'h00, 8'hFF, 1'b1);
      wait_out("s0xff", 1, 1);
      push_exp(16'h0000, 4'b0010);
      start_op(8'h00, 8'hFF, 1'b0);
      wait_out("u0xff", 1, 1);

      // 5: backpressure in DONE with a competing request
      push_exp(16'h0023, 4'b0000);
      start_op(8'd5, 8'd7, 1'b0);
      outReady = 1'b1;
      wait_out("bp", 1, 0);
      outReady = 1'b0;
      operand1   = 8'd3;
      operand2   = 8'd4;
      signedMode = 1'b0;
      inValid    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_outvalid_hold", outValid, 1);
         chk("bp_result_hold", result, 8'h23);
         chk("bp_status_hold", statusOut, 4'b0000);
         chk("bp_inready_low", inReady, 0);
      end
      push_exp(16'h000C, 4'b0000);
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      chk("bp_release_outvalid", outValid, 0);
      chk("bp_release_inready", inReady, 1);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      inValid = 1'b0;
      chk("bp_next_accepted", inReady, 0);
      wait_out("bp_next", 1, 1);

      // 6: reset during CALC iteration 3 aborts the operation
      push_exp(16'h0063, 4'b0000);
      start_op(8'd9, 8'd11, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      void'(sb.pop_front());
      chk("abort_outvalid", outValid, 0);
      chk("abort_inready", inReady, 1);
      chk("abort_product", product, 0);
      chk("abort_status", statusOut, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk);
         #1;
         if (outValid) chk("abort_no_output", outValid, 0);
      end
      push_exp(16'h002A, 4'b0000);
      start_op(8'd7, 8'd6, 1'b0);
      wait_out("post_abort", 1, 1);

      // Random operands in both modes against the native-multiply model
      for (int i = 0; i < 12; i++) begin
         logic [W-1:0] a, b;
         logic         s;
         a = W'($urandom);
         b = W'($urandom);
         s = 1'($urandom_range(0, 1));
         push_model(a, b, s);
         start_op(a, b, s);
         wait_out("rand", 1, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
